// File: rtl/alu_defs.sv
// ALU operation, ALUOp and funct encodings shared by the ID/EX stage and its ALU decoder.
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLTI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [3:0] operation;
    logic       illegal;
  } alu_ctl_t;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU decoder: {ALUOp, funct} -> 4-bit ALU operation plus an illegal-funct flag.
module alu_control
  import alu_defs::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctl_t   ctl
);

  always_comb begin
    ctl.operation = ALU_ADD;
    ctl.illegal   = 1'b0;
    case (alu_op)
      ALUOP_ADD:  ctl.operation = ALU_ADD;
      ALUOP_SUB:  ctl.operation = ALU_SUB;
      ALUOP_SLTI: ctl.operation = ALU_SLT;
      default: begin
        case (funct)
          FUNCT_ADD: ctl.operation = ALU_ADD;
          FUNCT_SUB: ctl.operation = ALU_SUB;
          FUNCT_AND: ctl.operation = ALU_AND;
          FUNCT_OR:  ctl.operation = ALU_OR;
          FUNCT_SLT: ctl.operation = ALU_SLT;
          // unsupported R-type: harmless add, flagged so EX can trap it
          default:   ctl.illegal   = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode, optional operand forwarding and ALUSrc/RegDst muxing.
// Define ID_EX_FWD_EN to enable forwarding of EX/MEM and MEM/WB results into the ALU operands.
module id_ex_stage
  import alu_defs::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [W-1:0]  id_pc4,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [15:0]   id_imm16,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [5:0]    id_funct,
  input  logic [1:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_branch,
  input  logic [1:0]    fwd_a_sel,
  input  logic [1:0]    fwd_b_sel,
  input  logic [W-1:0]  exmem_result,
  input  logic [W-1:0]  memwb_result,
  output logic          ex_valid,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_operation,
  output logic [W-1:0]  ex_mem_wdata,
  output logic [RW-1:0] ex_write_reg,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [W-1:0]  ex_pc4,
  output logic [W-1:0]  ex_imm,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_branch,
  output logic          ex_illegal
);

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  pc4;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] write_reg;
    logic [3:0]    operation;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          branch;
    logic          illegal;
  } ex_reg_t;

  alu_ctl_t ctl;
  ex_reg_t  ex_d, ex_q;
  logic [W-1:0] rs_value, rt_value;

  alu_control u_alu_control (
    .alu_op (id_alu_op),
    .funct  (id_funct),
    .ctl    (ctl)
  );

  // An invalid ID slot is captured exactly like a flush bubble.
  always_comb begin
    ex_d = '0;
    if (id_valid) begin
      ex_d.valid      = 1'b1;
      ex_d.pc4        = id_pc4;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = {{(W-16){id_imm16[15]}}, id_imm16};
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.write_reg  = id_reg_dst ? id_rd : id_rt;
      ex_d.operation  = ctl.operation;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_write  = id_reg_write & ~ctl.illegal;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write & ~ctl.illegal;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.branch     = id_branch;
      ex_d.illegal    = ctl.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) ex_q <= '0;
    else if (!stall)    ex_q <= ex_d;
  end

`ifdef ID_EX_FWD_EN
  always_comb begin
    case (fwd_a_sel)
      2'b10:   rs_value = exmem_result;
      2'b01:   rs_value = memwb_result;
      default: rs_value = ex_q.rs_data;
    endcase
    case (fwd_b_sel)
      2'b10:   rt_value = exmem_result;
      2'b01:   rt_value = memwb_result;
      default: rt_value = ex_q.rt_data;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, exmem_result, memwb_result};
  assign rs_value   = ex_q.rs_data;
  assign rt_value   = ex_q.rt_data;
`endif

  assign ex_valid      = ex_q.valid;
  assign alu_a         = rs_value;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : rt_value;
  assign alu_operation = ex_q.operation;
  assign ex_mem_wdata  = rt_value;
  assign ex_write_reg  = ex_q.write_reg;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_pc4        = ex_q.pc4;
  assign ex_imm        = ex_q.imm;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_branch     = ex_q.branch;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expectations queued at drive time, popped one edge later.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, exmem_result, memwb_result;
  logic [15:0] id_imm16;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op, fwd_a_sel, fwd_b_sel;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_branch;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_branch, ex_illegal;
  logic [31:0] alu_a, alu_b, ex_mem_wdata, ex_pc4, ex_imm;
  logic [3:0]  alu_operation;
  logic [4:0]  ex_write_reg, ex_rs, ex_rt;

  always #5 clk = ~clk;

  id_ex_stage #(.W(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .ex_mem_wdata(ex_mem_wdata), .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_pc4(ex_pc4), .ex_imm(ex_imm), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic        valid, rw, mr, mw, m2r, br, ill;
    logic [31:0] a, b, wd, pc4, imm;
    logic [3:0]  op;
    logic [4:0]  wr, rs, rt;
  } exp_t;

  exp_t q[$];
  exp_t e, last;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z = '{default: '0};
    return z;
  endfunction

  // Advance one edge, then pop the oldest expectation and compare every output.
  task automatic step(input string tag);
    exp_t x;
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    x = q.pop_front();
    chk({tag, ".valid"}, {31'd0, ex_valid},      {31'd0, x.valid});
    chk({tag, ".alu_a"}, alu_a,                  x.a);
    chk({tag, ".alu_b"}, alu_b,                  x.b);
    chk({tag, ".op"},    {28'd0, alu_operation}, {28'd0, x.op});
    chk({tag, ".wreg"},  {27'd0, ex_write_reg},  {27'd0, x.wr});
    chk({tag, ".rs"},    {27'd0, ex_rs},         {27'd0, x.rs});
    chk({tag, ".rt"},    {27'd0, ex_rt},         {27'd0, x.rt});
    chk({tag, ".wdata"}, ex_mem_wdata,           x.wd);
    chk({tag, ".pc4"},   ex_pc4,                 x.pc4);
    chk({tag, ".imm"},   ex_imm,                 x.imm);
    chk({tag, ".ctl"},
        {25'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal, 1'b0},
        {25'd0, x.rw, x.mr, x.mw, x.m2r, x.br, x.ill, 1'b0});
  endtask

  task automatic set_id(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                        input logic asrc, input logic rdst, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [15:0] imm,
                        input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic br);
    id_valid = v;  id_alu_op = aop; id_funct = fn; id_alu_src = asrc; id_reg_dst = rdst;
    id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r; id_branch = br;
  endtask

  logic [5:0] rfunct [6];
  logic [3:0] rop    [6];

  initial begin
    rfunct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    rop    = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b0010};
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; exmem_result = 32'd0; memwb_result = 32'd0;
    id_pc4 = 32'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    set_id(1'b1, 2'b10, 6'b100000, 1'b0, 1'b1, 32'd11, 32'd22, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    q.push_back(zero_exp());
    step("reset");
    reset = 1'b0;

    // R-type table: add, sub, and, or, slt, then unsupported funct 000000
    for (int i = 0; i < 6; i++) begin
      id_pc4 = 32'h100 + 32'(4 * i); id_rs = 5'd4; id_rt = 5'd5; id_rd = 5'd6;
      set_id(1'b1, 2'b10, rfunct[i], 1'b0, 1'b1, 32'(5 + i), 32'(7 + 3 * i),
             {10'h0c0, rfunct[i]}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      e = zero_exp();
      e.valid = 1'b1; e.a = 32'(5 + i); e.b = 32'(7 + 3 * i); e.wd = e.b; e.op = rop[i];
      e.wr = 5'd6; e.rs = 5'd4; e.rt = 5'd5; e.pc4 = 32'h100 + 32'(4 * i);
      e.imm = {16'd0, 10'h0c0, rfunct[i]};
      e.ill = (i == 5); e.rw = (i != 5);
      q.push_back(e);
      step($sformatf("rtype%0d", i));
    end

    // lw: sign-extended negative offset, dest = rt
    id_pc4 = 32'h200; id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd31;
    set_id(1'b1, 2'b00, 6'b111100, 1'b1, 1'b0, 32'd100, 32'd77, 16'hFFFC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    e = zero_exp();
    e.valid = 1'b1; e.a = 32'd100; e.b = 32'hFFFFFFFC; e.wd = 32'd77; e.op = 4'b0010;
    e.wr = 5'd9; e.rs = 5'd8; e.rt = 5'd9; e.pc4 = 32'h200; e.imm = 32'hFFFFFFFC;
    e.rw = 1'b1; e.mr = 1'b1; e.m2r = 1'b1;
    q.push_back(e);
    step("lw");

    // beq: ALUOp 01 -> sub, rt operand
    id_pc4 = 32'h204; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd0;
    set_id(1'b1, 2'b01, 6'b000011, 1'b0, 1'b0, 32'd40, 32'd40, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = zero_exp();
    e.valid = 1'b1; e.a = 32'd40; e.b = 32'd40; e.wd = 32'd40; e.op = 4'b0110;
    e.wr = 5'd2; e.rs = 5'd1; e.rt = 5'd2; e.pc4 = 32'h204; e.imm = 32'd3; e.br = 1'b1;
    q.push_back(e);
    step("beq");

    // slti: ALUOp 11 -> slt with positive immediate
    id_pc4 = 32'h208; id_rs = 5'd3; id_rt = 5'd10; id_rd = 5'd0;
    set_id(1'b1, 2'b11, 6'b000101, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd9, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = zero_exp();
    e.valid = 1'b1; e.a = 32'hFFFFFFFF; e.b = 32'd5; e.wd = 32'd9; e.op = 4'b0111;
    e.wr = 5'd10; e.rs = 5'd3; e.rt = 5'd10; e.pc4 = 32'h208; e.imm = 32'd5; e.rw = 1'b1;
    q.push_back(e);
    step("slti");

    // sw, then 3 stalled cycles with changing ID inputs
    id_pc4 = 32'h20c; id_rs = 5'd12; id_rt = 5'd13; id_rd = 5'd0;
    set_id(1'b1, 2'b00, 6'b001000, 1'b1, 1'b0, 32'h1000, 32'h55, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e = zero_exp();
    e.valid = 1'b1; e.a = 32'h1000; e.b = 32'd8; e.wd = 32'h55; e.op = 4'b0010;
    e.wr = 5'd13; e.rs = 5'd12; e.rt = 5'd13; e.pc4 = 32'h20c; e.imm = 32'd8; e.mw = 1'b1;
    q.push_back(e);
    step("sw");
    last = e;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_pc4 = 32'h300 + 32'(k); id_rs = 5'(20 + k); id_rt = 5'(21 + k); id_rd = 5'(22 + k);
      set_id(1'b1, 2'b10, 6'b100010, 1'b0, 1'b1, 32'(900 + k), 32'(800 + k), 16'h7FFF,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      q.push_back(last);
      step($sformatf("stall%0d", k));
    end

    // flush beats stall
    flush = 1'b1;
    q.push_back(zero_exp());
    step("flush_stall");
    flush = 1'b0; stall = 1'b0;

    // id_valid=0 is captured as a bubble
    set_id(1'b0, 2'b10, 6'b100000, 1'b1, 1'b1, 32'd123, 32'd456, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    q.push_back(zero_exp());
    step("invalid");

    // forwarding: only honoured when the feature is compiled in
    id_pc4 = 32'h400; id_rs = 5'd14; id_rt = 5'd15; id_rd = 5'd16;
    set_id(1'b1, 2'b10, 6'b100000, 1'b0, 1'b1, 32'd5, 32'd7, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fwd_a_sel = 2'b10; exmem_result = 32'd99; fwd_b_sel = 2'b01; memwb_result = 32'd3;
    e = zero_exp();
    e.valid = 1'b1; e.op = 4'b0010; e.wr = 5'd16; e.rs = 5'd14; e.rt = 5'd15;
    e.pc4 = 32'h400; e.rw = 1'b1;
`ifdef ID_EX_FWD_EN
    e.a = 32'd99; e.b = 32'd3; e.wd = 32'd3;
`else
    e.a = 32'd5;  e.b = 32'd7; e.wd = 32'd7;
`endif
    q.push_back(e);
    step("fwd");
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;

    // reset mid-stream overrides a pending load
    reset = 1'b1;
    set_id(1'b1, 2'b01, 6'b000000, 1'b1, 1'b0, 32'd1, 32'd2, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    q.push_back(zero_exp());
    step("reset_mid");
    reset = 1'b0;

    // first load after reset is normal
    id_pc4 = 32'h500; id_rs = 5'd17; id_rt = 5'd18; id_rd = 5'd19;
    set_id(1'b1, 2'b10, 6'b100101, 1'b0, 1'b1, 32'hF0F0, 32'h0F0F, 16'h9825, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = zero_exp();
    e.valid = 1'b1; e.a = 32'hF0F0; e.b = 32'h0F0F; e.wd = 32'h0F0F; e.op = 4'b0001;
    e.wr = 5'd19; e.rs = 5'd17; e.rt = 5'd18; e.pc4 = 32'h500; e.imm = 32'hFFFF9825; e.rw = 1'b1;
    q.push_back(e);
    step("post_reset");

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
